// File: rtl/fetch_sequencer_if.sv
// Bundles the instruction-memory handshake and the decoder/core-facing
// signals of the fetch sequencer. The sequencer takes the master modport;
// memory plus core (or a testbench) take the slave modport.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        advance;
  logic        pcsrc;
  logic        jump;
  logic [31:0] pcbranch;
  logic [31:0] retired;

  modport master (
    output imem_req, imem_addr, instr, op, funct, instr_valid, pc, pcplus4, retired,
    input  imem_ack, imem_rdata, advance, pcsrc, jump, pcbranch
  );

  modport slave (
    input  imem_req, imem_addr, instr, op, funct, instr_valid, pc, pcplus4, retired,
    output imem_ack, imem_rdata, advance, pcsrc, jump, pcbranch
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches one word at a time over
// a req/ack handshake, holds it for the decoder and picks the next PC
// (sequential, branch or jump) when the core retires the held instruction.
//
// state       | meaning
// ------------+--------------------------------------------------------
// FETCH_START | request issued at pc; an ack in this cycle is accepted
// FETCH_WAIT  | request outstanding, address held stable until ack
// HOLD        | instruction valid for the decoder, waiting for advance
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {FETCH_START, FETCH_WAIT, HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] pc_q, pc_next, pcplus4;
  logic [31:0] instr_q;
  logic [31:0] retired_q;
  logic        req;
  logic        capture;
  logic        retire;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH_START;
    else       state <= state_next;
  end

  // Next-state logic and handshake strobes.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    capture    = 1'b0;
    retire     = 1'b0;
    case (state)
      FETCH_START: begin
        req = 1'b1;
        if (bus.imem_ack) begin
          capture    = 1'b1;
          state_next = HOLD;
        end else begin
          state_next = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        req = 1'b1;
        if (bus.imem_ack) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (bus.advance) begin
          retire     = 1'b1;
          state_next = FETCH_START;
        end
      end
      default: state_next = FETCH_START;
    endcase
  end

  assign pcplus4 = pc_q + 32'd4;

  // Next-PC select; jump takes priority over a taken branch.
  always_comb begin
    pc_next = pcplus4;
    if (bus.jump)       pc_next = {pcplus4[31:28], instr_q[25:0], 2'b00};
    else if (bus.pcsrc) pc_next = {bus.pcbranch[31:2], 2'b00};
  end

  // Held instruction, PC and retirement counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= {RESET_PC[31:2], 2'b00};
      instr_q   <= 32'd0;
      retired_q <= 32'd0;
    end else begin
      if (capture) instr_q <= bus.imem_rdata;
      if (retire) begin
        pc_q      <= pc_next;
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  // Gating with reset drops the request the instant reset asserts, so an
  // in-flight fetch is abandoned without waiting for a clock edge.
  assign bus.imem_req    = req & ~reset;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.op          = instr_q[31:26];
  assign bus.funct       = instr_q[5:0];
  assign bus.instr_valid = (state == HOLD);
  assign bus.pc          = pc_q;
  assign bus.pcplus4     = pcplus4;
  assign bus.retired     = retired_q;

  // Branch targets are word-aligned; the low bits are dropped on purpose.
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.pcbranch[1:0]};

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a table of fetch/retire records drives a small
// memory/core model; expected fetch addresses and held words go through
// scoreboard queues and are compared when the DUT presents them.
module tb_fetch_sequencer;

  logic clk;
  logic reset;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    int          stall;
    logic        jump;
    logic        pcsrc;
    logic [31:0] pcbranch;
    logic [31:0] exp_next;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } held_t;

  vec_t        vecs[12];
  logic [31:0] addr_q[$];
  held_t       sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_pc, cur_instr, retired_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fetch_one(input int lat, input logic [31:0] rdata);
    int          n;
    logic [31:0] exp_addr;
    held_t       h;
    n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, bus.imem_req}, 32'd1);
    exp_addr = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hDEAD_BEEF;
    for (int c = 0; c <= lat; c++) begin
      chk("req_held", {31'd0, bus.imem_req}, 32'd1);
      chk("imem_addr", bus.imem_addr, exp_addr);
      chk("valid_low_fetch", {31'd0, bus.instr_valid}, 32'd0);
      bus.advance = 1'($urandom_range(0, 1));
      bus.jump    = 1'($urandom_range(0, 1));
      bus.pcsrc   = 1'($urandom_range(0, 1));
      bus.pcbranch = $urandom;
      if (c == lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = rdata;
        sb_q.push_back('{pc: exp_addr, instr: rdata});
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
      end
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    bus.advance  = 1'b0;
    if (bus.instr_valid && sb_q.size() > 0) begin
      h = sb_q.pop_front();
      chk("instr", bus.instr, h.instr);
      chk("op", {26'd0, bus.op}, {26'd0, h.instr[31:26]});
      chk("funct", {26'd0, bus.funct}, {26'd0, h.instr[5:0]});
      chk("pc", bus.pc, h.pc);
      chk("pcplus4", bus.pcplus4, h.pc + 32'd4);
      chk("req_low_hold", {31'd0, bus.imem_req}, 32'd0);
      cur_pc    = h.pc;
      cur_instr = h.instr;
    end else begin
      chk("valid_after_ack", {31'd0, bus.instr_valid}, 32'd1);
    end
  endtask

  task automatic hold_adv(input int stall, input logic jump, input logic pcsrc,
                          input logic [31:0] pcbranch, input logic [31:0] exp_next);
    for (int s = 0; s < stall; s++) begin
      bus.advance    = 1'b0;
      bus.imem_ack   = 1'(s % 2);
      bus.imem_rdata = $urandom;
      bus.jump       = 1'($urandom_range(0, 1));
      bus.pcsrc      = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stall_instr", bus.instr, cur_instr);
      chk("stall_pc", bus.pc, cur_pc);
      chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
      chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
    end
    bus.imem_ack = 1'b0;
    bus.advance  = 1'b1;
    bus.jump     = jump;
    bus.pcsrc    = pcsrc;
    bus.pcbranch = pcbranch;
    addr_q.push_back(exp_next);
    retired_exp = retired_exp + 32'd1;
    @(negedge clk);
    bus.advance = 1'b0;
    bus.jump    = 1'b0;
    bus.pcsrc   = 1'b0;
    chk("valid_drop", {31'd0, bus.instr_valid}, 32'd0);
    chk("req_after_adv", {31'd0, bus.imem_req}, 32'd1);
    chk("retired", bus.retired, retired_exp);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    //          lat  rdata          stall jump pcsrc pcbranch       exp_next
    vecs[0]  = '{0, 32'h2010_0005, 0,  1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004};
    vecs[1]  = '{3, 32'h0000_0020, 0,  1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008};
    vecs[2]  = '{1, 32'h8C01_0004, 0,  1'b0, 1'b0, 32'h0000_0100, 32'h0000_000C};
    vecs[3]  = '{0, 32'h1000_0003, 1,  1'b0, 1'b0, 32'h0000_0200, 32'h0000_0010};
    vecs[4]  = '{2, 32'h1022_0000, 0,  1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040};
    vecs[5]  = '{0, 32'h0000_0000, 10, 1'b0, 1'b1, 32'h1000_000B, 32'h1000_0008};
    vecs[6]  = '{0, 32'h0800_0010, 0,  1'b1, 1'b1, 32'h0000_0080, 32'h1000_0040};
    vecs[7]  = '{1, 32'h0800_0009, 0,  1'b0, 1'b1, 32'h0000_0024, 32'h0000_0024};
    vecs[8]  = '{0, 32'h1234_5678, 0,  1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[9]  = '{1, 32'hABCD_0001, 0,  1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{0, 32'h0800_0003, 2,  1'b1, 1'b0, 32'h0000_0000, 32'h0000_000C};
    vecs[11] = '{2, 32'h0000_002A, 0,  1'b0, 1'b0, 32'h0000_0000, 32'h0000_0010};

    reset          = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.advance    = 1'b0;
    bus.pcsrc      = 1'b0;
    bus.jump       = 1'b0;
    bus.pcbranch   = 32'd0;
    retired_exp    = 32'd0;
    cur_pc         = 32'd0;
    cur_instr      = 32'd0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_pc", bus.pc, 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_retired", bus.retired, 32'd0);
    reset = 1'b0;
    addr_q.push_back(32'h0000_0000);
    #1;

    for (int i = 0; i < 12; i++) begin
      if (i == 8) begin
        // Abandon a fetch at 0x24 mid-wait, then restart from RESET_PC.
        chk("pre_rst_req", {31'd0, bus.imem_req}, 32'd1);
        chk("pre_rst_addr", bus.imem_addr, addr_q.pop_front());
        @(negedge clk);
        chk("wait_addr", bus.imem_addr, 32'h0000_0024);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("midrst_pc", bus.pc, 32'd0);
        chk("midrst_retired", bus.retired, 32'd0);
        @(negedge clk);
        reset       = 1'b0;
        retired_exp = 32'd0;
        addr_q.push_back(32'h0000_0000);
        #1;
        chk("rel_req", {31'd0, bus.imem_req}, 32'd1);
      end
      fetch_one(vecs[i].lat, vecs[i].rdata);
      hold_adv(vecs[i].stall, vecs[i].jump, vecs[i].pcsrc, vecs[i].pcbranch, vecs[i].exp_next);
    end
    chk("final_addr", bus.imem_addr, addr_q.pop_front());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the instruction-fetch side of the CPU: owns the PC and fetches instruction words from instruction memory over a req/ack handshake.
- Presents each fetched word, with op and funct split out, to the main decoder.
- Consumes the decoder's pcsrc/jump results on retirement to select the next PC: sequential, branch or jump.
- Allows multi-cycle instruction memory and a variable-latency core without changing the decoder.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  word-aligned fetch address
- imem_ack  input  1  memory returns imem_rdata this cycle
- imem_rdata  input  32  instruction word, valid only with imem_ack
- instr  output  32  held instruction word
- op  output  6  instr[31:26]
- funct  output  6  instr[5:0]
- instr_valid  output  1  instr/op/funct valid for the decoder
- pc  output  32  address of the held instruction
- pcplus4  output  32  pc + 4
- advance  input  1  core retires the held instruction this cycle
- pcsrc  input  1  branch taken (from decoder), sampled with advance
- jump  input  1  jump (from decoder), sampled with advance
- pcbranch  input  32  branch target, sampled with advance
- retired  output  32  count of retired instructions

Behaviour:
- Reset (async, active-high), all values while reset is asserted:
  - state = FETCH_START, pc = RESET_PC, instr = 0, retired = 0.
  - imem_req = 0, instr_valid = 0.
- FSM has three states: FETCH_START, FETCH_WAIT, HOLD.
- FETCH_START:
  - imem_req = 1, imem_addr = pc.
  - If imem_ack is high in this same cycle, capture imem_rdata into instr and go to HOLD.
  - Otherwise go to FETCH_WAIT.
- FETCH_WAIT:
  - imem_req stays 1; imem_addr stays = pc and stable.
  - On imem_ack, capture imem_rdata into instr and go to HOLD.
- HOLD:
  - imem_req = 0, instr_valid = 1.
  - On advance, compute next pc (priority order):
    1. jump: {pcplus4[31:28], instr[25:0], 2'b00}
    2. else pcsrc: {pcbranch[31:2], 2'b00}
    3. else pcplus4
  - On advance, also increment retired (wraps 32'hFFFF_FFFF -> 0) and go to FETCH_START.
- Latency:
  - First imem_req is high in the first clock after reset deasserts.
  - ack in cycle N -> instr_valid = 1 in cycle N+1.
  - advance in cycle M -> instr_valid = 0 and imem_req = 1 with the new address in cycle M+1.
  - Minimum 2 cycles per instruction.
- Ignored inputs:
  - imem_ack while imem_req = 0 (HOLD) is ignored; instr is unchanged.
  - advance, pcsrc, jump and pcbranch are ignored outside HOLD.
  - pcsrc and jump are don't-care when advance = 0.
- Outputs are held: instr, op, funct and pc change only on capture or advance. The decoder may look at them combinationally while in HOLD.
- Reset asserted mid-fetch: imem_req drops to 0 immediately (async) and the outstanding request is abandoned. A late ack arriving after reset release, while in FETCH_START, is accepted as data for RESET_PC; the memory must not ack an abandoned request after reset.
- pc[1:0] and imem_addr[1:0] are always 2'b00.
- pcplus4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- All arithmetic is unsigned 32-bit modulo.

Test Plan:
- Reset release, memory acks immediately with 32'h2010_0005 -> imem_addr = 0 in cycle 1; instr_valid = 1 in cycle 2; op = 6'h08; pc = 0; retired = 0.
- Ack delayed 3 cycles -> imem_req and imem_addr = 32'h4 held for all 4 cycles; instr captured once; instr_valid = 1 the cycle after ack.
- pc = 32'h0000_0010, advance with pcsrc = 1, pcbranch = 32'h0000_0040 -> next imem_addr = 32'h40; retired increments by 1.
- pc = 32'h1000_0008, instr = 32'h0800_0010, advance with jump = 1 and pcsrc = 1 -> next imem_addr = 32'h1000_0040 (jump wins over branch).
- Stall: hold advance = 0 for 10 cycles in HOLD while toggling imem_ack -> instr and pc unchanged; imem_req = 0 throughout.
- Assert reset during FETCH_WAIT at pc = 32'h24 -> imem_req = 0 immediately; after release imem_addr = RESET_PC; retired = 0.
